sha_pad_ctrl: RTL

//  Message sequencer in front of the SHA-256 core (sha_in/sha_out datapath). Accepts a
//  32-bit word stream per message, builds 512-bit blocks, and appends FIPS 180-4 padding
//  (0x80, zero fill, 64-bit bit length). Issues one core_enable pulse per block, waits for

---
 rtl/sha_pad_ctrl_if.sv | 31 +++
 rtl/sha_pad_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sha_pad_ctrl_if.sv
// Handshake and datapath bundle between a message source, the SHA padding
// sequencer and the SHA-256 compression core.
`timescale 1ns/1ps
interface sha_pad_ctrl_if #(
  parameter int NB = 512,
  parameter int NK = 256
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [1:0]    in_bytes;
  logic [NB-1:0] core_data;
  logic          core_init;
  logic          core_enable;
  logic          core_ready;
  logic [NK-1:0] core_hash;
  logic          hash_valid;
  logic [NK-1:0] hash;
  logic          hash_ack;

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_ready, core_hash, hash_ack,
    input  in_ready, core_data, core_init, core_enable, hash_valid, hash
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_ready, core_hash, hash_ack,
    output in_ready, core_data, core_init, core_enable, hash_valid, hash
  );
endinterface

// File: rtl/sha_pad_ctrl.sv
// Message sequencer ahead of the SHA-256 core: packs 32-bit words into 512-bit
// blocks, appends 0x80 / zero fill / bit length, and hands the final digest on.
`timescale 1ns/1ps
module sha_pad_ctrl #(
  parameter int Nb    = 512,
  parameter int Nk    = 256,
  parameter int LEN_W = 64
) (
  input logic           clk,
  input logic           rst,
  sha_pad_ctrl_if.slave bus
);

  localparam logic [2:0] FILL = 3'd0;
  localparam logic [2:0] PAD  = 3'd1;
  localparam logic [2:0] LEN0 = 3'd2;
  localparam logic [2:0] LEN1 = 3'd3;
  localparam logic [2:0] SEND = 3'd4;
  localparam logic [2:0] WAIT = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]       state_r, state_s;
  logic [3:0]       idx_r, idx_s;
  logic [LEN_W-1:0] bitlen_r, bitlen_s;
  logic             first_r, first_s;
  logic             pad_done_r, pad_done_s;
  logic             msg_open_r, msg_open_s;
  logic             final_r, final_s;
  logic [Nb-1:0]    core_data_r;
  logic             in_ready_r, core_enable_r, core_init_r;
  logic             hash_valid_r, hash_valid_s;
  logic [Nk-1:0]    hash_r;
  logic             accept_s, wr_s, clear_s, hash_load_s;
  logic [31:0]      wdata_s, last_word_s, word_s;
  logic [5:0]       nbits_s;
  logic [63:0]      len64_s;

  assign bus.in_ready    = in_ready_r;
  assign bus.core_data   = core_data_r;
  assign bus.core_init   = core_init_r;
  assign bus.core_enable = core_enable_r;
  assign bus.hash_valid  = hash_valid_r;
  assign bus.hash        = hash_r;

  // Input word shaping: zero unused tail bytes and drop the 0x80 marker after them.
  always_comb begin
    case (bus.in_bytes)
      2'd1:    last_word_s = {bus.in_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word_s = {bus.in_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word_s = {bus.in_data[31:8], 8'h80};
      default: last_word_s = bus.in_data;
    endcase
    if (bus.in_last) begin
      word_s  = last_word_s;
      nbits_s = (bus.in_bytes == 2'd0) ? 6'd32 : {1'b0, bus.in_bytes, 3'b000};
    end else begin
      word_s  = bus.in_data;
      nbits_s = 6'd32;
    end
    len64_s  = 64'(bitlen_r);
    accept_s = bus.in_valid & in_ready_r;
  end

  // Sequencing: next state, which slot gets which word, and message bookkeeping.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    bitlen_s     = bitlen_r;
    first_s      = first_r;
    pad_done_s   = pad_done_r;
    msg_open_s   = msg_open_r;
    final_s      = final_r;
    hash_valid_s = hash_valid_r;
    wr_s         = 1'b0;
    wdata_s      = 32'h0000_0000;
    clear_s      = 1'b0;
    hash_load_s  = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          wr_s     = 1'b1;
          wdata_s  = word_s;
          idx_s    = idx_r + 4'd1;
          bitlen_s = bitlen_r + LEN_W'(nbits_s);
          if (bus.in_last) begin
            pad_done_s = (bus.in_bytes != 2'd0);
            msg_open_s = 1'b0;
            if (idx_r == 4'd15) begin
              state_s = SEND;
              final_s = 1'b0;
            end else if ((idx_s == 4'd14) && pad_done_s) begin
              state_s = LEN0;
            end else begin
              state_s = PAD;
            end
          end else if (idx_r == 4'd15) begin
            state_s    = SEND;
            final_s    = 1'b0;
            msg_open_s = 1'b1;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      PAD: begin
        wr_s       = 1'b1;
        wdata_s    = pad_done_r ? 32'h0000_0000 : 32'h8000_0000;
        pad_done_s = 1'b1;
        idx_s      = idx_r + 4'd1;
        // Slot 15 reached without room for the length: it spills into an extra block.
        if (idx_r == 4'd15) begin
          state_s = SEND;
          final_s = 1'b0;
        end else if (idx_s == 4'd14) begin
          state_s = LEN0;
        end else begin
          state_s = PAD;
        end
      end
      LEN0: begin
        wr_s    = 1'b1;
        wdata_s = len64_s[63:32];
        idx_s   = idx_r + 4'd1;
        state_s = LEN1;
      end
      LEN1: begin
        wr_s    = 1'b1;
        wdata_s = len64_s[31:0];
        idx_s   = 4'd0;
        final_s = 1'b1;
        state_s = SEND;
      end
      SEND: begin
        first_s = 1'b0;
        state_s = WAIT;
      end
      WAIT: begin
        if (bus.core_ready) begin
          if (final_r) begin
            hash_load_s  = 1'b1;
            hash_valid_s = 1'b1;
            state_s      = DONE;
          end else begin
            idx_s   = 4'd0;
            clear_s = 1'b1;
            state_s = msg_open_r ? FILL : PAD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        if (bus.hash_ack) begin
          hash_valid_s = 1'b0;
          bitlen_s     = '0;
          first_s      = 1'b1;
          pad_done_s   = 1'b0;
          msg_open_s   = 1'b0;
          final_s      = 1'b0;
          idx_s        = 4'd0;
          clear_s      = 1'b1;
          state_s      = FILL;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // State, block buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FILL;
      idx_r         <= 4'd0;
      bitlen_r      <= '0;
      first_r       <= 1'b1;
      pad_done_r    <= 1'b0;
      msg_open_r    <= 1'b0;
      final_r       <= 1'b0;
      core_data_r   <= '0;
      in_ready_r    <= 1'b0;
      core_enable_r <= 1'b0;
      core_init_r   <= 1'b0;
      hash_valid_r  <= 1'b0;
      hash_r        <= '0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      bitlen_r      <= bitlen_s;
      first_r       <= first_s;
      pad_done_r    <= pad_done_s;
      msg_open_r    <= msg_open_s;
      final_r       <= final_s;
      in_ready_r    <= (state_s == FILL);
      core_enable_r <= (state_s == SEND);
      core_init_r   <= (state_s == SEND) & first_r;
      hash_valid_r  <= hash_valid_s;
      if (hash_load_s) begin
        hash_r <= bus.core_hash;
      end else begin
        hash_r <= hash_r;
      end
      // Slot idx occupies bits 511-32*idx downwards (word0 at the top).
      if (clear_s) begin
        core_data_r <= '0;
      end else if (wr_s) begin
        core_data_r[{~idx_r, 5'b11111} -: 32] <= wdata_s;
      end else begin
        core_data_r <= core_data_r;
      end
    end
  end

endmodule
